// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-period math.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  // Clock cycles per UART bit, truncated.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Ready/valid stream carrying received UART words downstream.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 tvalid;
  logic                 tready;
  logic [DATA_BITS-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; flops load RESET_VAL in reset.
module sync_2ff #(
  parameter int             WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // Two back-to-back flops to settle metastability before use.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing (DATA_BITS configurable), ready/valid output.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around each sample
// point; the decision is taken one cycle later so the third sample is available.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line high, waiting for a falling edge
// ST_START | timing to mid start bit, rejecting glitches
// ST_DATA  | sampling data bits LSB-first, one per bit period
// ST_STOP  | sampling stop bit; good word or framing error
// ST_BREAK | line stuck low after framing error, wait for high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic      clk,
  input  logic      aresetn,
  input  logic      serial_data,
  uart_rx_if.master m_axis,
  output logic      framing_error,
  output logic      overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS + 1);
  localparam int MID          = CLKS_PER_BIT / 2 - 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int START_PT = MID + 1;
  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: majority vote needs at least 4 clocks per bit");
  end
`else
  localparam int START_PT = MID;
  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_rx: need at least 2 clocks per bit");
  end
`endif

  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_PT);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 sample_bit;
  uart_state_t          state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 word_done, frame_err;
  logic                 tvalid_q;
  logic [DATA_BITS-1:0] tdata_q;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .aresetn (aresetn),
    .d       (serial_data),
    .q       (rx_s)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Keep the two previous synchronised samples for the vote window.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) hist_q <= 2'b11;
    else          hist_q <= {hist_q[0], rx_s};
  end

  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (baud_q == START_CNT) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = sample_bit ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == LAST_CNT) begin
          baud_d  = '0;
          shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_q == LAST_CNT) begin
          baud_d = '0;
          if (sample_bit) begin
            word_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = ST_BREAK;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_BREAK: begin
        baud_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output holding register; a word arriving while it is still full is dropped.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= frame_err;
      overrun       <= 1'b0;
      if (tvalid_q && m_axis.tready) tvalid_q <= 1'b0;
      if (word_done) begin
        if (!tvalid_q || m_axis.tready) begin
          tdata_q  <= shift_q;
          tvalid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit, 8 data bits.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic serial_data = 1'b1;
  logic framing_error, overrun;

  uart_rx_if #(.DATA_BITS(8)) m_if ();

  uart_rx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .DATA_BITS (8)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .serial_data   (serial_data),
    .m_axis        (m_if),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int hs_cnt = 0, tv_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] last_data = '0;

  // Event monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    if (aresetn) begin
      if (m_if.tvalid) tv_cnt++;
      if (m_if.tvalid && m_if.tready) begin
        hs_cnt++;
        last_data = m_if.tdata;
      end
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    hs_cnt = 0;
    tv_cnt = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    last_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drives the first nbits of a frame (start, data LSB-first, stop), 10 cycles each;
  // glitch inverts cycle 5 of every data bit.
  task automatic send(input logic [7:0] data, input bit stop_bit, input int nbits, input bit glitch);
    logic [9:0] fr;
    fr = {stop_bit, data, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      for (int j = 0; j < 10; j++) begin
        @(posedge clk);
        #1;
        serial_data = (glitch && b >= 1 && b <= 8 && j == 5) ? ~fr[b] : fr[b];
      end
    end
  endtask

  initial begin
    logic [7:0] exp_glitch;
    m_if.tready = 1'b1;
    #2;
    check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_ferr", 32'(framing_error), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    idle(3);
    #1 aresetn = 1'b1;
    clear_mon();

    // Plain frame with downstream always ready.
    send(8'hA5, 1'b1, 10, 1'b0);
    idle(5);
    check("a5_hs", hs_cnt, 1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_tv_cycles", tv_cnt, 1);
    check("a5_ferr", fe_cnt, 0);
    check("a5_ovr", ov_cnt, 0);

    // Short low glitch must be rejected.
    clear_mon();
    @(posedge clk);
    #1 serial_data = 1'b0;
    idle(3);
    #1 serial_data = 1'b1;
    idle(20);
    check("glitch_hs", hs_cnt, 0);
    check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
    send(8'h3C, 1'b1, 10, 1'b0);
    idle(5);
    check("3c_hs", hs_cnt, 1);
    check("3c_data", 32'(last_data), 32'h3C);

    // Bad stop bit followed by a held-low line.
    clear_mon();
    send(8'h55, 1'b0, 10, 1'b0);
    idle(50);
    check("brk_ferr", fe_cnt, 1);
    check("brk_hs", hs_cnt, 0);
    check("brk_tv", tv_cnt, 0);
    check("brk_state", 32'(dut.state_q), 32'(ST_BREAK));
    #1 serial_data = 1'b1;
    idle(5);
    check("brk_exit_state", 32'(dut.state_q), 32'(ST_IDLE));
    send(8'h81, 1'b1, 10, 1'b0);
    idle(5);
    check("81_hs", hs_cnt, 1);
    check("81_data", 32'(last_data), 32'h81);
    check("81_ferr_total", fe_cnt, 1);

    // Overrun with downstream stalled.
    clear_mon();
    #1 m_if.tready = 1'b0;
    send(8'h11, 1'b1, 10, 1'b0);
    send(8'h22, 1'b1, 10, 1'b0);
    idle(5);
    check("ovr_tvalid", 32'(m_if.tvalid), 32'd1);
    check("ovr_tdata", 32'(m_if.tdata), 32'h11);
    check("ovr_pulses", ov_cnt, 1);
    check("ovr_hs", hs_cnt, 0);
    #1 m_if.tready = 1'b1;
    idle(3);
    check("ovr_drain_hs", hs_cnt, 1);
    check("ovr_drain_data", 32'(last_data), 32'h11);
    check("ovr_drain_tvalid", 32'(m_if.tvalid), 32'd0);

    // Asynchronous reset in the middle of a frame.
    clear_mon();
    send(8'hF0, 1'b1, 4, 1'b0);
    aresetn = 1'b0;
    #1;
    check("mid_rst_tdata", 32'(m_if.tdata), 32'd0);
    check("mid_rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("mid_rst_baud", 32'(dut.baud_q), 32'd0);
    serial_data = 1'b1;
    idle(3);
    #1 aresetn = 1'b1;
    idle(5);
    send(8'h0F, 1'b1, 10, 1'b0);
    idle(5);
    check("0f_hs", hs_cnt, 1);
    check("0f_data", 32'(last_data), 32'h0F);
    check("0f_ferr", fe_cnt, 0);

    // Mid-bit single-cycle glitch on every data bit.
    clear_mon();
`ifdef UART_RX_MAJORITY_VOTE_EN
    exp_glitch = 8'h96;
`else
    exp_glitch = 8'h69;
`endif
    send(8'h96, 1'b1, 10, 1'b1);
    idle(5);
    check("96_hs", hs_cnt, 1);
    check("96_data", 32'(last_data), 32'(exp_glitch));
    check("96_ferr", fe_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100e6, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division).
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; frame = 1 start (0), DATA_BITS LSB-first, 1 stop (1), no parity.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 aresetn  input  1  reset, asynchronous and active-low.
REQ-006 serial_data  input  1  asynchronous UART line, idle high.
REQ-007 m_axis_tvalid  output  1  received word available.
REQ-008 m_axis_tready  input  1  downstream accepts word.
REQ-009 m_axis_tdata  output  DATA_BITS  received word.
REQ-010 framing_error  output  1  one-cycle pulse: stop bit sampled 0.
REQ-011 overrun  output  1  one-cycle pulse: completed word dropped because output register full.

Function
REQ-012 serial_data SHALL pass through a 2-flop synchroniser (flops reset to 1); all decisions use the synchronised value.
REQ-013 Baud counter width SHALL be $clog2(CLKS_PER_BIT); bit counter width $clog2(DATA_BITS+1); mid-bit point MID = CLKS_PER_BIT/2 - 1.
REQ-014 States: IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: synchronised line 0 -> START, baud counter cleared.
REQ-016 START: at baud count MID sample; 1 -> IDLE (glitch rejected, no output); 0 -> DATA, counters cleared.
REQ-017 DATA: each bit sampled when baud counter reaches CLKS_PER_BIT-1 (i.e. mid-bit, one bit period after previous sample), shifted in LSB-first; after DATA_BITS samples -> STOP.
REQ-018 STOP: sample one bit period after last data sample; 1 -> word complete, IDLE; 0 -> framing_error pulse, word discarded, BREAK.
REQ-019 BREAK: remain until synchronised line 1, then IDLE; no start detection while line held low.
REQ-020 On word complete with m_axis_tvalid=0, or m_axis_tvalid=1 and m_axis_tready=1 same cycle: m_axis_tdata loaded, m_axis_tvalid=1 on next clock.
REQ-021 On word complete with m_axis_tvalid=1 and m_axis_tready=0: new word dropped, held word unchanged, overrun pulses one cycle.
REQ-022 m_axis_tvalid SHALL stay 1 and m_axis_tdata stable until handshake; tvalid never depends combinationally on tready.
REQ-023 Receiver SHALL continue receiving while output register is full.

Reset
REQ-024 Asserting aresetn low SHALL immediately force: state IDLE, counters 0, m_axis_tvalid 0, m_axis_tdata 0, framing_error 0, overrun 0, synchroniser flops 1.
REQ-025 Reset mid-frame SHALL discard the partial frame; after release a low line is treated as a new start bit only after passing the synchroniser.

Configuration
REQ-026 Macro UART_RX_MAJORITY_VOTE_EN defined: every sample point (start, data, stop) SHALL use 2-of-3 majority of synchronised line at counts sample-1, sample, sample+1; elaboration error if CLKS_PER_BIT < 4.
REQ-027 Macro not defined: single sample at the sample point; elaboration error if CLKS_PER_BIT < 2.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum type and a function computing CLKS_PER_BIT; shared with uart_tx.
REQ-029 Sub-module sync_2ff (parameterised width, reset value) SHALL implement the synchroniser; all else in uart_rx.

Verification (CLK_FREQ=1e6, BAUD_RATE=100000, CLKS_PER_BIT=10, DATA_BITS=8)
REQ-030 Frame 0xA5, m_axis_tready=1 -> m_axis_tdata=0xA5, tvalid one cycle, no error pulses.
REQ-031 Line low 3 cycles then high -> no output, state returns to IDLE; following frame 0x3C received correctly.
REQ-032 Frame 0x55 with stop bit 0, line held low 50 cycles -> framing_error one pulse, no tvalid, no restart until line high; next 0x81 received.
REQ-033 Frames 0x11 then 0x22, tready=0 throughout -> tdata=0x11 held, overrun one pulse; tready=1 then yields 0x11 only.
REQ-034 aresetn low mid-data of 0xF0 -> outputs zero immediately; next frame 0x0F received correctly.
REQ-035 With UART_RX_MAJORITY_VOTE_EN, single-cycle inverted glitch at mid-bit of each bit of 0x96 -> 0x96 received; without macro -> corrupted word reported.
